// File: rtl/conv_pkg.sv
// Shared widths, symbols and byte-lane helper for the 32b->8b serializer.
package conv_pkg;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [BYTE_W-1:0] COM_SYMBOL = 8'hBC;

  typedef logic [1:0] byte_idx_t;

  // Returns the byte transmitted in slot idx of word, honouring the chosen byte order.
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                  input byte_idx_t idx,
                                                  input logic msb_first);
    byte_idx_t pos;
    pos = msb_first ? byte_idx_t'(2'd3 - idx) : idx;
    return word[pos*BYTE_W +: BYTE_W];
  endfunction
endpackage

// File: rtl/conv_word_buf.sv
// One-entry holding register that lets the producer hand over the next word early.
module conv_word_buf
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              full
);
  logic [WORD_W-1:0] data_reg;
  logic              full_reg;

  // The writer only writes while empty, so a write and a read never coincide.
  always_ff @(posedge clk) begin
    if (srst) begin
      data_reg <= '0;
      full_reg <= 1'b0;
    end else if (wr_en) begin
      data_reg <= din;
      full_reg <= 1'b1;
    end else if (rd_en) begin
      full_reg <= 1'b0;
    end
  end

  assign dout = data_reg;
  assign full = full_reg;
endmodule

// File: rtl/conv_32b_8b.sv
// Serializes 32-bit words into a gap-free byte stream, one byte per clk_4f cycle.
// Optional macro IDLE_BC_EN: drive IDLE_SYMBOL instead of 8'h00 while valid_out is low.
module conv_32b_8b
  import conv_pkg::*;
#(
  parameter int                MSB_FIRST   = 1,
  parameter logic [BYTE_W-1:0] IDLE_SYMBOL = COM_SYMBOL
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              sop_out
);
`ifdef IDLE_BC_EN
  localparam bit IDLE_BC = 1'b1;
`else
  localparam bit IDLE_BC = 1'b0;
`endif
  localparam logic [BYTE_W-1:0] IDLE_VAL = IDLE_BC ? IDLE_SYMBOL : 8'h00;
  localparam logic ORDER_MSB = (MSB_FIRST != 0);

  byte_idx_t         idx_reg, idx_next;
  logic [WORD_W-1:0] sh_reg, sh_next;
  logic [BYTE_W-1:0] data_out_reg, data_out_next;
  logic              valid_out_reg, valid_out_next;
  logic              sop_out_reg, sop_out_next;

  logic              buf_wr, buf_rd, buf_full;
  logic [WORD_W-1:0] buf_dout;
  logic [BYTE_W-1:0] lane [BYTES_PER_WORD];

  conv_word_buf u_buf (
    .clk   (clk_4f),
    .srst  (reset),
    .wr_en (buf_wr),
    .rd_en (buf_rd),
    .din   (data_in),
    .dout  (buf_dout),
    .full  (buf_full)
  );

  // Bytes of the current word, indexed in transmission order.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    assign lane[gi] = pick_byte(sh_reg, byte_idx_t'(gi), ORDER_MSB);
  end

  assign ready_out = !reset && !buf_full;

  always_comb begin
    idx_next       = idx_reg;
    sh_next        = sh_reg;
    data_out_next  = IDLE_VAL;
    valid_out_next = 1'b0;
    sop_out_next   = 1'b0;
    buf_wr         = 1'b0;
    buf_rd         = 1'b0;
    if (idx_reg == 2'd0) begin
      // A buffered word always takes priority; otherwise a new word bypasses the buffer.
      if (buf_full) begin
        sh_next        = buf_dout;
        data_out_next  = pick_byte(buf_dout, 2'd0, ORDER_MSB);
        valid_out_next = 1'b1;
        sop_out_next   = 1'b1;
        idx_next       = 2'd1;
        buf_rd         = 1'b1;
      end else if (valid_in) begin
        sh_next        = data_in;
        data_out_next  = pick_byte(data_in, 2'd0, ORDER_MSB);
        valid_out_next = 1'b1;
        sop_out_next   = 1'b1;
        idx_next       = 2'd1;
      end
    end else begin
      data_out_next  = lane[idx_reg];
      valid_out_next = 1'b1;
      idx_next       = idx_reg + 2'd1;
      buf_wr         = valid_in && ready_out;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      idx_reg       <= 2'd0;
      sh_reg        <= '0;
      data_out_reg  <= IDLE_VAL;
      valid_out_reg <= 1'b0;
      sop_out_reg   <= 1'b0;
    end else begin
      idx_reg       <= idx_next;
      sh_reg        <= sh_next;
      data_out_reg  <= data_out_next;
      valid_out_reg <= valid_out_next;
      sop_out_reg   <= sop_out_next;
    end
  end

  assign data_out  = data_out_reg;
  assign valid_out = valid_out_reg;
  assign sop_out   = sop_out_reg;
endmodule
